// File: rtl/aes_decrypt_iter_if.sv
// Bus between a block source and aes_decrypt_iter: start/busy/done handshake,
// ciphertext in, plaintext out and the flattened round-key schedule.
// With AES_DEC_ABORT_EN defined the bus also carries an abort request.
interface aes_decrypt_iter_if #(
    parameter int unsigned Nr = 10
) ();
    logic                   start;
    logic [127:0]           data_in;
    logic [(Nr+1)*128-1:0]  all_keys;
    logic [127:0]           data_out;
    logic                   busy;
    logic                   done;
`ifdef AES_DEC_ABORT_EN
    logic                   abort;

    modport master (output start, data_in, all_keys, abort, input data_out, busy, done);
    modport slave  (input start, data_in, all_keys, abort, output data_out, busy, done);
`else
    modport master (output start, data_in, all_keys, input data_out, busy, done);
    modport slave  (input start, data_in, all_keys, output data_out, busy, done);
`endif
endinterface

// File: rtl/aes_decrypt_iter.sv
// Iterative AES inverse cipher (AES-128/192/256), one round per clock.
// Round keys come from the same flattened KeyExpansion bus as the encryptor
// (key 0 at the MSBs). Optional AES_DEC_ABORT_EN adds bus.abort, which drops
// an in-flight block without pulsing done or touching data_out.
module aes_decrypt_iter #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = 10
) (
    input logic               clk,
    input logic               rst,
    aes_decrypt_iter_if.slave bus
);
    localparam int unsigned KeyW = (Nr + 1) * 128;
    localparam int unsigned CntW = $clog2(Nr + 1);

    localparam logic [7:0] InvSbox [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {StIdle, StRound, StLast} fsm_e;

    fsm_e             fsm_q, fsm_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [127:0]     st_q, st_d;
    logic [127:0]     dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_req;
    logic [127:0]     rk [Nr+1];

    // AES pairs each key length with a fixed round count.
    nr_matches_nk: assert property (@(posedge clk) disable iff (rst) Nr == Nk + 6);

    for (genvar i = 0; i <= Nr; i++) begin : g_rk
        assign rk[i] = bus.all_keys[KeyW-1-128*i -: 128];
    end

`ifdef AES_DEC_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // InvShiftRows followed by InvSubBytes; row r of column c comes from column c-r.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = InvSbox[s[127-8*(4*((c+4-r)%4)+r) -: 8]];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a, x2, x4, x8;
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a     = col[31-8*i -: 8];
            x2    = xtime(a);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ a;
            mb[i] = x8 ^ x2 ^ a;
            md[i] = x8 ^ x4 ^ a;
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // State registers; reset abandons any block in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q  <= StIdle;
            cnt_q  <= '0;
            st_q   <= '0;
            dout_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            dout_q <= dout_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Next-state: initial AddRoundKey on accept, Nr-1 full rounds, then the final round.
    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        dout_d = dout_q;
        busy_d = busy_q;
        done_d = 1'b0;
        unique case (fsm_q)
            StIdle: begin
                if (bus.start) begin
                    st_d   = bus.data_in ^ rk[Nr];
                    cnt_d  = CntW'(Nr - 1);
                    busy_d = 1'b1;
                    fsm_d  = StRound;
                end
            end
            StRound: begin
                if (abort_req) begin
                    busy_d = 1'b0;
                    fsm_d  = StIdle;
                end else begin
                    st_d = inv_mix_columns(inv_shift_sub(st_q) ^ rk[cnt_q]);
                    if (cnt_q == CntW'(1)) begin
                        fsm_d = StLast;
                    end else begin
                        cnt_d = cnt_q - CntW'(1);
                    end
                end
            end
            StLast: begin
                busy_d = 1'b0;
                fsm_d  = StIdle;
                if (!abort_req) begin
                    dout_d = inv_shift_sub(st_q) ^ rk[0];
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
                fsm_d  = StIdle;
            end
        endcase
    end

    assign bus.data_out = dout_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule
